multi_debounce: RTL and testbench
=================================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 SHALL have parameter N, default 4: number of independent input channels, 1..32.
REQ-002 SHALL have parameter PRESCALE, default 1000: clk cycles per debounce tick, at least 1.
REQ-003 SHALL have parameter STABLE_TICKS, default 10: ticks an input must hold before it is accepted, 1..65535.
REQ-004 SHALL have parameter LONG_TICKS, default 1000: ticks of accepted-high before long_press fires, greater than STABLE_TICKS.
REQ-005 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in, input, N bits: raw asynchronous button or contact inputs.
REQ-008 SHALL have port level, output, N bits: debounced level, registered.
REQ-009 SHALL have port rise, output, N bits: one-cycle pulse on accepted 0->1.
REQ-010 SHALL have port fall, output, N bits: one-cycle pulse on accepted 1->0.
REQ-011 SHALL have port long_press, output, N bits: one-cycle pulse when level stays high for LONG_TICKS ticks.

Function
REQ-012 SHALL pass each in bit through a two-flop synchronizer before any use; call the result sync.
REQ-013 SHALL contain one shared prescaler counting 0..PRESCALE-1 and wrapping to 0; tick is asserted while the count equals PRESCALE-1; PRESCALE=1 means tick is asserted every cycle.
REQ-014 SHALL give each channel its own FSM with states LOW, PEND_HI, HIGH, PEND_LO, plus a stability counter of width clog2(STABLE_TICKS+1).
REQ-015 SHALL apply these transitions:
- LOW: sync=1 -> PEND_HI, counter cleared.
- PEND_HI: sync=0 -> LOW; else tick with counter=STABLE_TICKS-1 -> HIGH; else tick -> counter+1.
- HIGH: sync=0 -> PEND_LO, counter cleared.
- PEND_LO: sync=1 -> HIGH; else tick with counter=STABLE_TICKS-1 -> LOW; else tick -> counter+1.
REQ-016 SHALL, when sync bounces and tick coincide in a cycle, give the bounce priority (return to the stable state) over the tick.
REQ-017 SHALL drive level high in HIGH and PEND_LO and low in LOW and PEND_HI, so level is glitch-free during a pending release.
REQ-018 SHALL assert rise for exactly the cycle after a PEND_HI->HIGH transition, and fall for exactly the cycle after a PEND_LO->LOW transition.
REQ-019 SHALL give each channel a hold counter that clears on entry to HIGH, increments on tick while in HIGH or PEND_LO, and saturates at LONG_TICKS.
REQ-020 SHALL pulse long_press for one cycle when the hold counter reaches LONG_TICKS, at most once per press.
REQ-021 SHALL, when PRESCALE=1, assert level and rise STABLE_TICKS+3 clk edges after a clean in step.
REQ-022 SHALL keep channels fully independent; simultaneous events on different channels SHALL each produce their own pulses in the same cycle.
REQ-023 SHALL make the accepted debounce time lie between STABLE_TICKS-1 and STABLE_TICKS tick periods; this tick-phase jitter is allowed.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously force all synchronizer flops, the prescaler, all counters and every output to 0, and all FSMs to LOW.
REQ-025 SHALL, on reset mid-press, discard all pending state; a still-high input after release of reset SHALL be re-debounced from LOW, producing a rise and no fall.

Structure
REQ-026 SHALL place the FSM state encoding (LOW=0, PEND_HI=1, HIGH=2, PEND_LO=3) in the shared package debounce_pkg.
REQ-027 SHALL implement one channel (FSM, stability counter, hold counter, pulse registers) as sub-module debounce_channel, instantiated N times; the synchronizer and prescaler SHALL stay in the top level.

Verification
Scenarios use N=4, PRESCALE=1, STABLE_TICKS=4, LONG_TICKS=16.
REQ-028 SHALL cover a clean step: in[0] 0->1 held -> level[0]=1 and a one-cycle rise[0] 7 edges later; no other channel changes.
REQ-029 SHALL cover bounce rejection: in[1] high for 3 cycles, low for 1, repeated 5 times, then low -> level[1], rise[1] and fall[1] stay 0 throughout.
REQ-030 SHALL cover release glitch: with level[2]=1, in[2] low for 2 cycles then high -> level[2] stays 1 and no fall[2] is produced.
REQ-031 SHALL cover long press: in[3] held high for 30 cycles -> exactly one long_press[3] pulse, 16 ticks after rise[3].
REQ-032 SHALL cover reset mid-press: reset_n pulsed low while in[0]=1 and level[0]=1 -> all outputs 0 immediately; after reset release, rise[0] recurs 7 edges later.
REQ-033 SHALL cover simultaneous events: all four inputs stepped in the same cycle -> rise=4'b1111 in one cycle, then level=4'b1111.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types for the multi-channel debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_PEND_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_PEND_LO = 2'd3
    } db_state_e;

    // True in the states where the debounced level reads high.
    function automatic logic level_of(input db_state_e s);
        return (s == ST_HIGH) || (s == ST_PEND_LO);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: FSM, stability counter, hold counter and pulse registers.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 10,
    parameter int LONG_TICKS   = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);

    db_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            level_d, rise_d, fall_d, long_d;

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // Next state: a bounce back to the stable level wins over a coinciding tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_LOW: if (sync) begin
                state_d = ST_PEND_HI;
                cnt_d   = '0;
            end
            ST_PEND_HI: begin
                if (!sync)
                    state_d = ST_LOW;
                else if (tick) begin
                    if (cnt_q == CW'(STABLE_TICKS - 1)) state_d = ST_HIGH;
                    else                                cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_HIGH: if (!sync) begin
                state_d = ST_PEND_LO;
                cnt_d   = '0;
            end
            ST_PEND_LO: begin
                if (sync)
                    state_d = ST_HIGH;
                else if (tick) begin
                    if (cnt_q == CW'(STABLE_TICKS - 1)) state_d = ST_LOW;
                    else                                cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_LOW;
        endcase
    end

    // Outputs and hold counter; a release glitch (PEND_LO -> HIGH) stays part of the
    // same press, so the hold count only restarts on a fresh accepted press.
    always_comb begin
        level_d = level_of(state_d);
        rise_d  = (state_q == ST_PEND_HI) && (state_d == ST_HIGH);
        fall_d  = (state_q == ST_PEND_LO) && (state_d == ST_LOW);
        hold_d  = hold_q;
        long_d  = 1'b0;
        if (rise_d)
            hold_d = '0;
        else if (tick && level_of(state_q) && hold_q != HW'(LONG_TICKS)) begin
            hold_d = hold_q + HW'(1);
            long_d = (hold_q == HW'(LONG_TICKS - 1));
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            long_press <= 1'b0;
        end else begin
            level      <= level_d;
            rise       <= rise_d;
            fall       <= fall_d;
            long_press <= long_d;
        end
    end

endmodule

// File: rtl/multi_debounce.sv
// N-channel debouncer: per-bit synchronizer, one shared tick prescaler, N channels.
module multi_debounce
    import debounce_pkg::*;
#(
    parameter int N            = 4,
    parameter int PRESCALE     = 1000,
    parameter int STABLE_TICKS = 10,
    parameter int LONG_TICKS   = 1000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] in,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] long_press
);

    // PRESCALE=1 still needs a 1-bit counter that simply stays at 0.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [N-1:0]  sync_q1, sync;
    logic [PW-1:0] pre_q;
    logic          tick;

    // Two-flop synchronizer on every raw input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync    <= '0;
        end else begin
            sync_q1 <= in;
            sync    <= sync_q1;
        end
    end

    assign tick = (pre_q == PW'(PRESCALE - 1));

    // Shared prescaler, wraps after PRESCALE-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  pre_q <= '0;
        else if (tick) pre_q <= '0;
        else           pre_q <= pre_q + PW'(1);
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .sync       (sync[i]),
            .tick       (tick),
            .level      (level[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .long_press (long_press[i])
        );
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Scoreboard bench for multi_debounce (N=4, PRESCALE=1, STABLE_TICKS=4, LONG_TICKS=16).
module tb_multi_debounce;

    localparam int N = 4;

    typedef struct packed {
        int unsigned cyc;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  lp;
        logic [3:0]  lvl;
    } ev_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] din = '0;
    logic [N-1:0] level, rise, fall, long_press;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    ev_t         exp_q[$];

    multi_debounce #(
        .N(N), .PRESCALE(1), .STABLE_TICKS(4), .LONG_TICKS(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in         (din),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .long_press (long_press)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic expect_ev(input int unsigned c, input logic [3:0] r, input logic [3:0] f,
                             input logic [3:0] l, input logic [3:0] v);
        ev_t e;
        e.cyc = c; e.rise = r; e.fall = f; e.lp = l; e.lvl = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse the DUT presents is matched against the next expected event.
    always @(negedge clk) begin
        if (reset_n && (rise | fall | long_press) != '0) begin
            ev_t a, e;
            a.cyc = cyc; a.rise = rise; a.fall = fall; a.lp = long_press; a.lvl = level;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: cyc=%0d rise=%b fall=%b long=%b level=%b, none expected",
                         a.cyc, a.rise, a.fall, a.lp, a.lvl);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL event: got cyc=%0d rise=%b fall=%b long=%b level=%b want cyc=%0d rise=%b fall=%b long=%b level=%b",
                             a.cyc, a.rise, a.fall, a.lp, a.lvl, e.cyc, e.rise, e.fall, e.lp, e.lvl);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;

        // Reset state
        wait_cyc(3);
        check("reset_level", level, 4'b0000);
        check("reset_rise",  rise,  4'b0000);
        check("reset_fall",  fall,  4'b0000);
        check("reset_long",  long_press, 4'b0000);
        reset_n = 1'b1;
        wait_cyc(3);

        // Clean step on channel 0, then reset while it is held high
        c = cyc; din[0] = 1'b1;
        expect_ev(c + 7, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        wait_cyc(12);
        check("pre_reset_level", level, 4'b0001);
        reset_n = 1'b0;
        #1;
        check("mid_reset_level", level, 4'b0000);
        check("mid_reset_pulses", rise | fall | long_press, 4'b0000);
        wait_cyc(2);
        c = cyc; reset_n = 1'b1;
        expect_ev(c + 7,  4'b0001, 4'b0000, 4'b0000, 4'b0001);
        expect_ev(c + 23, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        wait_cyc(30);
        c = cyc; din[0] = 1'b0;
        expect_ev(c + 7, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_cyc(15);

        // Bouncing input on channel 1 never gets accepted
        for (int r = 0; r < 5; r++) begin
            din[1] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                wait_cyc(1);
                check("bounce_level1", {3'b000, level[1]}, 4'b0000);
            end
            din[1] = 1'b0;
            wait_cyc(1);
        end
        for (int k = 0; k < 8; k++) begin
            wait_cyc(1);
            check("bounce_level1", {3'b000, level[1]}, 4'b0000);
        end

        // Release glitch on channel 2: level stays high, no fall until a real release
        c = cyc; din[2] = 1'b1;
        expect_ev(c + 7, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        wait_cyc(10);
        din[2] = 1'b0;
        wait_cyc(2);
        din[2] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_cyc(1);
            check("glitch_level2", {3'b000, level[2]}, 4'b0001);
        end
        c = cyc; din[2] = 1'b0;
        expect_ev(c + 7, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            wait_cyc(1);
            check("pend_lo_level2", {3'b000, level[2]}, 4'b0001);
        end
        wait_cyc(10);

        // Long press on channel 3
        c = cyc; din[3] = 1'b1;
        expect_ev(c + 7,  4'b1000, 4'b0000, 4'b0000, 4'b1000);
        expect_ev(c + 23, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
        expect_ev(c + 37, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
        wait_cyc(30);
        din[3] = 1'b0;
        wait_cyc(15);

        // All channels stepped together
        c = cyc; din = 4'b1111;
        expect_ev(c + 7,  4'b1111, 4'b0000, 4'b0000, 4'b1111);
        expect_ev(c + 23, 4'b0000, 4'b0000, 4'b1111, 4'b1111);
        expect_ev(c + 32, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        wait_cyc(25);
        din = 4'b0000;
        wait_cyc(15);
        check("final_level", level, 4'b0000);

        // Anything still queued was never seen
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event: got nothing want cyc=%0d rise=%b fall=%b long=%b",
                     e.cyc, e.rise, e.fall, e.lp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
